// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: per channel a synchroniser, a saturating
// up/down integrator, a hysteresis comparator and registered edge strobes.

module sync_filter_lane #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CTR_WIDTH   = 4,
    parameter int   HIGH_THRESH = 12,
    parameter int   LOW_THRESH  = 3,
    parameter logic RESET_VAL   = 1'b0,
    parameter logic INVERT      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic async_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] HI_T    = CTR_WIDTH'(HIGH_THRESH);
    localparam logic [CTR_WIDTH-1:0] LO_T    = CTR_WIDTH'(LOW_THRESH);
    localparam logic [CTR_WIDTH-1:0] CTR_RST = RESET_VAL ? CTR_MAX : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CTR_WIDTH-1:0]   ctr_q;
    logic [CTR_WIDTH-1:0]   ctr_d;
    logic                   s;
    logic                   clean_d;
    logic                   init;

    assign init = rst_i | clr_i;

    // Plain flop chain; the clear is the only thing besides the shift.
    always_ff @(posedge clk_i) begin
        if (init) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end

    always_comb begin
        s       = sync_q[SYNC_STAGES-1] ^ INVERT;
        ctr_d   = ctr_q;
        clean_d = clean_o;
        if (s && (ctr_q != CTR_MAX))      ctr_d = ctr_q + CTR_ONE;
        else if (!s && (ctr_q != '0))     ctr_d = ctr_q - CTR_ONE;
        // Hysteresis looks at the registered count, not ctr_d.
        if (ctr_q >= HI_T)                clean_d = 1'b1;
        else if (ctr_q <= LO_T)           clean_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (init) begin
            ctr_q   <= CTR_RST;
            clean_o <= RESET_VAL;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else if (en_i) begin
            ctr_q   <= ctr_d;
            clean_o <= clean_d;
            rise_o  <= clean_d & ~clean_o;
            fall_o  <= ~clean_d & clean_o;
        end else begin
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end
    end
endmodule

module sync_filter_bank #(
    parameter int              N_CH        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              CTR_WIDTH   = 4,
    parameter int              HIGH_THRESH = 12,
    parameter int              LOW_THRESH  = 3,
    parameter logic [N_CH-1:0] RESET_VAL   = {N_CH{1'b0}},
    parameter logic [N_CH-1:0] INVERT      = {N_CH{1'b0}}
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [N_CH-1:0] clr_i,
    input  logic [N_CH-1:0] async_i,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);
    localparam int CTR_MAX_I = (1 << CTR_WIDTH) - 1;

    if (!((LOW_THRESH < HIGH_THRESH) && (HIGH_THRESH <= CTR_MAX_I))) begin : g_bad_thresh
        $fatal(1, "sync_filter_bank: need LOW_THRESH < HIGH_THRESH <= 2^CTR_WIDTH-1");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $fatal(1, "sync_filter_bank: SYNC_STAGES must be 2..4");
    end
    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $fatal(1, "sync_filter_bank: N_CH must be 1..32");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sync_filter_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .CTR_WIDTH   (CTR_WIDTH),
            .HIGH_THRESH (HIGH_THRESH),
            .LOW_THRESH  (LOW_THRESH),
            .RESET_VAL   (RESET_VAL[g]),
            .INVERT      (INVERT[g])
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .clr_i   (clr_i[g]),
            .async_i (async_i[g]),
            .clean_o (clean_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
        );
    end
endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: directed vector table, hand sequences for latency,
// glitch, enable and clear cases, then random traffic against a queue-based model.

module tb_sync_filter_bank;
    localparam int N    = 4;
    localparam int CMAX = 15;
    localparam logic [N-1:0] RV_A  = 4'b0101;
    localparam logic [N-1:0] INV_A = 4'b0000;
    localparam logic [N-1:0] RV_B  = 4'b0011;
    localparam logic [N-1:0] INV_B = 4'b1010;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] clr;
    logic [N-1:0] av;
    logic [N-1:0] clean_a, rise_a, fall_a;
    logic [N-1:0] clean_b, rise_b, fall_b;

    sync_filter_bank #(.N_CH(N), .SYNC_STAGES(2), .CTR_WIDTH(4), .HIGH_THRESH(12),
                       .LOW_THRESH(3), .RESET_VAL(RV_A), .INVERT(INV_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .async_i(av),
        .clean_o(clean_a), .rise_o(rise_a), .fall_o(fall_a));

    sync_filter_bank #(.N_CH(N), .SYNC_STAGES(3), .CTR_WIDTH(4), .HIGH_THRESH(10),
                       .LOW_THRESH(5), .RESET_VAL(RV_B), .INVERT(INV_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .async_i(av),
        .clean_o(clean_b), .rise_o(rise_b), .fall_o(fall_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: raw input history per channel, integer counter, level.
    int           p_ss[2]  = '{2, 3};
    int           p_hi[2]  = '{12, 10};
    int           p_lo[2]  = '{3, 5};
    logic [N-1:0] p_rv[2];
    logic [N-1:0] p_inv[2];
    bit           hist[2][N][$];
    int           m_ctr[2][N];
    logic [N-1:0] m_clean[2], m_rise[2], m_fall[2];
    bit           m_init = 0;
    int           rise_cnt[N], fall_cnt[N];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic cmpv(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                bit   s;
                logic nc;
                if (rst || clr[c]) begin
                    hist[d][c].delete();
                    repeat (p_ss[d]) hist[d][c].push_back(1'b0);
                    m_ctr[d][c]   = p_rv[d][c] ? CMAX : 0;
                    m_clean[d][c] = p_rv[d][c];
                    m_rise[d][c]  = 1'b0;
                    m_fall[d][c]  = 1'b0;
                end else begin
                    s  = hist[d][c][0] ^ p_inv[d][c];
                    nc = m_clean[d][c];
                    if (m_ctr[d][c] >= p_hi[d])      nc = 1'b1;
                    else if (m_ctr[d][c] <= p_lo[d]) nc = 1'b0;
                    if (en) begin
                        m_rise[d][c]  = nc & ~m_clean[d][c];
                        m_fall[d][c]  = ~nc & m_clean[d][c];
                        m_clean[d][c] = nc;
                        if (s) m_ctr[d][c] = (m_ctr[d][c] < CMAX) ? m_ctr[d][c] + 1 : CMAX;
                        else   m_ctr[d][c] = (m_ctr[d][c] > 0) ? m_ctr[d][c] - 1 : 0;
                    end else begin
                        m_rise[d][c] = 1'b0;
                        m_fall[d][c] = 1'b0;
                    end
                    hist[d][c].push_back(av[c]);
                    void'(hist[d][c].pop_front());
                end
            end
        end
        if (rst) m_init = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_init) begin
            cmpv("a_clean", clean_a, m_clean[0]);
            cmpv("a_rise",  rise_a,  m_rise[0]);
            cmpv("a_fall",  fall_a,  m_fall[0]);
            cmpv("b_clean", clean_b, m_clean[1]);
            cmpv("b_rise",  rise_b,  m_rise[1]);
            cmpv("b_fall",  fall_b,  m_fall[1]);
        end
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] += int'(rise_a[c]);
            fall_cnt[c] += int'(fall_a[c]);
        end
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
    endtask

    task automatic wait_lat(input int ch, input logic val, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (clean_a[ch] === val) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] clr;
        logic [N-1:0] av;
        int           ncyc;
        logic [N-1:0] exp_clean;
        logic [N-1:0] exp_rise;
        logic [N-1:0] exp_fall;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [N-1:0] rmask, fmask;
        int n;
        p_rv[0] = RV_A;  p_rv[1] = RV_B;
        p_inv[0] = INV_A; p_inv[1] = INV_B;
        rst = 1'b1; en = 1'b0; clr = '0; av = '0;

        //            rst   en    clr   async    cyc clean    rise     fall
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'b0101,  1, 4'b0101, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 4'b0101, 20, 4'b0101, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'b0100, 14, 4'b0101, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'b0100,  1, 4'b0100, 4'b0000, 4'b0001};
        tbl[4]  = '{1'b0, 1'b1, 4'h0, 4'b0100, 20, 4'b0100, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 1'b1, 4'h0, 4'b0101, 14, 4'b0100, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b0, 1'b1, 4'h0, 4'b0101,  1, 4'b0101, 4'b0001, 4'b0000};
        tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'b0101, 30, 4'b0101, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 1'b1, 4'h0, 4'b0100, 14, 4'b0101, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'b0100,  1, 4'b0100, 4'b0000, 4'b0001};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 4'b1011,  5, 4'b0100, 4'b0000, 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[k]) begin
            rst = tbl[k].rst; en = tbl[k].en; clr = tbl[k].clr; av = tbl[k].av;
            clr_cnt();
            repeat (tbl[k].ncyc) tick();
            for (int c = 0; c < N; c++) begin
                rmask[c] = (rise_cnt[c] != 0);
                fmask[c] = (fall_cnt[c] != 0);
                chk($sformatf("vec%0d_strobe_count_ch%0d", k, c), rise_cnt[c] + fall_cnt[c],
                    int'(tbl[k].exp_rise[c]) + int'(tbl[k].exp_fall[c]));
            end
            cmpv($sformatf("vec%0d_clean", k), clean_a, tbl[k].exp_clean);
            cmpv($sformatf("vec%0d_rise", k), rmask, tbl[k].exp_rise);
            cmpv($sformatf("vec%0d_fall", k), fmask, tbl[k].exp_fall);
        end

        // Settle: ch0 low, ch1 low, ch2 high, ch3 low.
        en = 1'b1; av = 4'b0100;
        repeat (20) tick();

        // Glitch on ch1: alternating input, then 11 highs (peak below threshold).
        clr_cnt();
        for (int i = 0; i < 40; i++) begin
            av[1] = i[0];
            tick();
        end
        chk("glitch_clean", int'(clean_a[1]), 0);
        av[1] = 1'b0; repeat (10) tick();
        av[1] = 1'b1; repeat (11) tick();
        av[1] = 1'b0; repeat (22) tick();
        chk("peak11_clean", int'(clean_a[1]), 0);
        chk("glitch_strobes", rise_cnt[1] + fall_cnt[1], 0);

        // Exactly 12 highs reach the threshold: rise at edge 15.
        av[1] = 1'b1; n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 12) av[1] = 1'b0;
            if (clean_a[1] === 1'b1 && n < 0) n = i;
        end
        chk("peak12_rise_edge", n, 15);
        repeat (10) tick();

        // Enable freeze on ch2 mid-count adds the frozen cycles to the latency.
        av[2] = 1'b0; repeat (25) tick();
        chk("en_pre_clean", int'(clean_a[2]), 0);
        clr_cnt();
        av[2] = 1'b1; n = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 9)  en = 1'b0;
            if (i == 19) en = 1'b1;
            tick();
            if (i == 18) chk("en_frozen_clean", int'(clean_a[2]), 0);
            if (clean_a[2] === 1'b1 && n < 0) n = i;
        end
        chk("en_rise_edge", n, 25);
        chk("en_rise_count", rise_cnt[2], 1);

        // Clear ch3 at ctr=8, then restart; later clear while clean=1.
        av[3] = 1'b1; repeat (10) tick();
        clr[3] = 1'b1; tick(); clr[3] = 1'b0;
        chk("clr_clean", int'(clean_a[3]), 0);
        chk("clr_rise", int'(rise_a[3]), 0);
        wait_lat(3, 1'b1, 40, n);
        chk("clr_restart_edge", n, 15);
        repeat (5) tick();
        clr[3] = 1'b1; tick(); clr[3] = 1'b0;
        chk("clr_hi_clean", int'(clean_a[3]), 0);
        chk("clr_hi_fall", int'(fall_a[3]), 0);
        chk("clr_other_ch", int'(clean_a[2]), 1);

        // Reset beats clear and an input edge.
        av = 4'b1010; clr = 4'b1111; rst = 1'b1;
        tick();
        rst = 1'b0; clr = '0;
        cmpv("rst_clean", clean_a, 4'b0101);
        cmpv("rst_rise", rise_a, 4'b0000);
        cmpv("rst_fall", fall_a, 4'b0000);
        repeat (3) tick();

        // Random traffic: sticky inputs, occasional enable drops, clears, resets.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 11) == 0) av[c] = ~av[c];
            en = ($urandom_range(0, 19) != 0);
            for (int c = 0; c < N; c++)
                clr[c] = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0; clr = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
- Multi-channel successor of the single-input synchroniser/debouncer, for the voltmeter front-end: comparator outputs, range switches and push-buttons.
- Each channel has the following chain:
  - a parametrised-depth synchroniser;
  - a saturating up/down integrator counter;
  - a hysteresis comparator producing a clean level;
  - registered one-cycle rise and fall strobes.
- Adds to the earlier block: per-channel reset level and input inversion, a global count enable, and per-channel clear.

Parameters:
- N_CH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flop depth (2..4).
- CTR_WIDTH, 4: integrator width; CTR_MAX = 2^CTR_WIDTH-1.
- HIGH_THRESH, 12: clean level sets when counter >= HIGH_THRESH.
- LOW_THRESH, 3: clean level clears when counter <= LOW_THRESH.
- RESET_VAL, {N_CH{1'b0}}: per-channel clean level after reset.
- INVERT, {N_CH{1'b0}}: per-channel polarity; a 1 inverts the synchronised input before the integrator.

Ports:
- clk_i  in  1  single clock for all state.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- en_i  in  1  count enable; 0 freezes counters and clean levels, synchronisers keep running.
- clr_i  in  N_CH  per-channel synchronous clear to reset state, one cycle wide.
- async_i  in  N_CH  raw asynchronous inputs.
- clean_o  out  N_CH  filtered levels.
- rise_o  out  N_CH  one-cycle strobe in the first cycle clean_o[i] reads 1.
- fall_o  out  N_CH  one-cycle strobe in the first cycle clean_o[i] reads 0.

Behaviour:
- Elaboration checks; $fatal if any of these fails:
  - LOW_THRESH < HIGH_THRESH <= CTR_MAX;
  - SYNC_STAGES >= 2.
- Reset (rst_i=1 at a clk_i edge) sets:
  - sync flops to 0;
  - ctr[i] = RESET_VAL[i] ? CTR_MAX : 0;
  - clean_o[i] = RESET_VAL[i];
  - rise_o = 0 and fall_o = 0.
- rst_i has priority over clr_i and en_i. Reset mid-operation discards all counter state and emits no strobes.
- clr_i[i]=1: channel i takes its reset state on that edge. Its sync flops are also cleared. No strobe on the clear edge, even if clean_o[i] changes.
- Synchroniser: s[i] = last flop of a SYNC_STAGES chain, XORed with INVERT[i]. No other logic is allowed in the chain.
- Integrator, when en_i=1 and not cleared:
  - s=1 and ctr<CTR_MAX: ctr+1;
  - s=0 and ctr>0: ctr-1;
  - otherwise hold. Saturates at both ends and never wraps.
- en_i=0: ctr and clean hold. rise_o and fall_o are 0.
- Hysteresis on the registered counter:
  - ctr >= HIGH_THRESH: clean <= 1;
  - ctr <= LOW_THRESH: clean <= 0;
  - otherwise hold.
- Strobes are registered on the same edge as clean_o:
  - rise_o[i] = next clean & ~clean_o;
  - fall_o[i] = ~next clean & clean_o.
  - Never both set. High for exactly one cycle per transition.
- Latency, counted in clk_i edges after async_i changes (defaults, counter starting at rail):
  - rising from ctr=0: clean_o rises at edge SYNC_STAGES+HIGH_THRESH+1 = 15;
  - falling from ctr=CTR_MAX: clean_o falls at edge SYNC_STAGES+(CTR_MAX-LOW_THRESH)+1 = 15.
- Channels are fully independent. No cross-channel state.
- All outputs are registered. No combinational path from async_i.

Test Plan:
- Reset with RESET_VAL=4'b0101 → clean_o=0101, rise_o=0, fall_o=0. Hold async_i=0101 for 20 cycles → no strobes.
- async_i[0] 0→1 at an edge → clean_o[0]=0 through edge 14, 1 at edge 15. rise_o[0] high for cycle 15 only.
- Hold async_i[0]=1 for 30 cycles (saturates at 15), then drop to 0 → clean_o[0] falls at edge 15. fall_o[0] pulses once.
- Glitch and hysteresis:
  - async_i[1] alternating 1/0 every cycle for 40 cycles → clean_o[1] stays 0, no strobes;
  - 11 high cycles then 2 low (ctr peaks at 11) → clean_o[1] stays 0.
- en_i=0 for 10 cycles while async_i[2]=1 mid-count → clean_o[2] unchanged, no strobe. After en_i=1 the count resumes from the frozen value and clean_o[2] rises with 10 extra cycles of delay.
- Clear and reset mid-operation:
  - clr_i[3] pulse with ctr[3]=8 → ctr[3]=0 and clean_o[3]=RESET_VAL[3] next cycle; other channels unaffected;
  - rst_i asserted together with clr_i and an async edge → reset values win, no strobes.
